word_packer_credit: RTL and testbench

WORD_PACKER_CREDIT -- requirements
Module: word_packer_credit

---
 rtl/word_packer_credit_pkg.sv | 19 +
 rtl/word_packer_credit_if.sv | 26 ++
 rtl/word_packer_credit_credit_counter.sv | 49 ++++
 rtl/word_packer_credit.sv | 115 +++++++++++
 tb/tb_word_packer_credit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/word_packer_credit_pkg.sv
// Shared types and constants for the 16-bit word packer and its credit counter.
package word_packer_credit_pkg;

    localparam int WORD_W = 16;
    localparam int WORDS  = 16;
    localparam int WCNT_W = 5;
    localparam int CRED_W = 6;

    typedef enum logic {
        FILL        = 1'b0,
        WAIT_CREDIT = 1'b1
    } state_e;

    // A full buffer of 16 words wraps to size 0 on the 4-bit size field.
    function automatic logic [3:0] enc_size(input logic [WCNT_W-1:0] n);
        return n[3:0];
    endfunction

endpackage

// File: rtl/word_packer_credit_if.sv
// Upstream word stream plus downstream FIFO write/credit signals of the packer.
interface word_packer_credit_if;
    import word_packer_credit_pkg::*;

    logic [WORD_W-1:0]       s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic                    flush;
    logic [WORDS*WORD_W-1:0] data_o;
    logic [3:0]              size_o;
    logic                    data_we;
    logic                    credit_ret;
    logic [CRED_W-1:0]       credit_cnt;
    logic                    credit_err;

    modport slave (
        input  s_data, s_valid, flush, credit_ret,
        output s_ready, data_o, size_o, data_we, credit_cnt, credit_err
    );

    modport master (
        output s_data, s_valid, flush, credit_ret,
        input  s_ready, data_o, size_o, data_we, credit_cnt, credit_err
    );

endinterface

// File: rtl/word_packer_credit_credit_counter.sv
// Downstream word-credit tracker: subtracts consumed words, adds returned ones,
// and drops (with a sticky error) any return that would exceed the initial pool.
module credit_counter
    import word_packer_credit_pkg::*;
#(
    parameter int CREDIT_INIT = 32
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [WCNT_W-1:0] consume,
    input  logic              ret,
    output logic [CRED_W-1:0] cnt,
    output logic              err
);

    localparam logic [CRED_W:0] INIT_X = (CRED_W+1)'(CREDIT_INIT);

    logic [CRED_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [CRED_W:0]   base;

    always_comb begin
        // consume never exceeds cnt_q, so base cannot wrap
        base  = {1'b0, cnt_q} - {2'b00, consume};
        cnt_d = base[CRED_W-1:0];
        err_d = err_q;
        if (ret) begin
            if (base + 1'b1 > INIT_X) begin
                err_d = 1'b1;
            end else begin
                cnt_d = base[CRED_W-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q <= INIT_X[CRED_W-1:0];
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt = cnt_q;
    assign err = err_q;

endmodule

// File: rtl/word_packer_credit.sv
// Packs 16-bit words into 16-slot lines and writes them downstream when full,
// flushed or idle, but only once the downstream FIFO has room for the whole line.
module word_packer_credit
    import word_packer_credit_pkg::*;
#(
    parameter int CREDIT_INIT = 32,
    parameter int TIMEOUT     = 8
) (
    input  logic               clk,
    input  logic               reset_p,
    word_packer_credit_if.slave bus
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_e                        state_q, state_d;
    logic [WCNT_W-1:0]             wcnt_q, wcnt_d;
    logic [WORDS-1:0][WORD_W-1:0]  buf_q, buf_d;
    logic                          flush_pend_q, flush_pend_d;
    logic [7:0]                    idle_cnt_q, idle_cnt_d;
    logic                          data_we_q, data_we_d;
    logic [WORDS-1:0][WORD_W-1:0]  data_o_q, data_o_d;
    logic [3:0]                    size_o_q, size_o_d;

    logic [CRED_W-1:0] credit_cnt;
    logic [WCNT_W-1:0] consume;
    logic              emit_req, credit_ok, emit_go, s_ready, xfer;

    credit_counter #(.CREDIT_INIT(CREDIT_INIT)) u_credit (
        .clk     (clk),
        .reset_p (reset_p),
        .consume (consume),
        .ret     (bus.credit_ret),
        .cnt     (credit_cnt),
        .err     (bus.credit_err)
    );

    always_comb begin
        emit_req = (wcnt_q == 5'd16) ||
                   ((wcnt_q != '0) && (flush_pend_q || idle_cnt_q == TO));
        credit_ok = credit_cnt >= {1'b0, wcnt_q};
        emit_go   = emit_req && credit_ok;
        s_ready   = !reset_p && (wcnt_q < 5'd16) && !emit_req;
        xfer      = bus.s_valid && s_ready;

        state_d      = state_q;
        wcnt_d       = wcnt_q;
        buf_d        = buf_q;
        flush_pend_d = flush_pend_q;
        idle_cnt_d   = idle_cnt_q;
        data_we_d    = 1'b0;
        data_o_d     = data_o_q;
        size_o_d     = size_o_q;
        consume      = '0;

        if (xfer) begin
            buf_d[wcnt_q[3:0]] = bus.s_data;
            wcnt_d             = wcnt_q + 1'b1;
            idle_cnt_d         = '0;
        end else if (wcnt_q != '0 && idle_cnt_q != TO) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (bus.flush && (wcnt_q != '0 || xfer)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            FILL:        if (emit_req && !credit_ok) state_d = WAIT_CREDIT;
            WAIT_CREDIT: if (emit_go) state_d = FILL;
            default:     state_d = FILL;
        endcase

        // Emission cycle never overlaps a transfer since s_ready is low.
        if (emit_go) begin
            data_we_d    = 1'b1;
            data_o_d     = buf_q;
            size_o_d     = enc_size(wcnt_q);
            consume      = wcnt_q;
            wcnt_d       = '0;
            buf_d        = '0;
            flush_pend_d = 1'b0;
            idle_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q      <= FILL;
            wcnt_q       <= '0;
            buf_q        <= '0;
            flush_pend_q <= 1'b0;
            idle_cnt_q   <= '0;
            data_we_q    <= 1'b0;
            data_o_q     <= '0;
            size_o_q     <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            buf_q        <= buf_d;
            flush_pend_q <= flush_pend_d;
            idle_cnt_q   <= idle_cnt_d;
            data_we_q    <= data_we_d;
            data_o_q     <= data_o_d;
            size_o_q     <= size_o_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.data_o     = data_o_q;
    assign bus.size_o     = size_o_q;
    assign bus.data_we    = data_we_q;
    assign bus.credit_cnt = credit_cnt;

endmodule

// File: tb/tb_word_packer_credit.sv
// Directed bench for word_packer_credit: full/flush/timeout emissions, credit stall,
// credit overflow and mid-operation reset.
module tb_word_packer_credit;
    import word_packer_credit_pkg::*;

    logic clk     = 1'b0;
    logic reset_p = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    word_packer_credit_if bus();

    word_packer_credit #(.CREDIT_INIT(32), .TIMEOUT(8)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_p        = 1'b1;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.flush      = 1'b0;
        bus.credit_ret = 1'b0;
        cyc();
        cyc();
        reset_p = 1'b0;
        #1;
    endtask

    // Leaves s_valid high so consecutive calls stream back-to-back.
    task automatic feed(input logic [15:0] d);
        int t;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        t = 0;
        while (!bus.s_ready && t < 100) begin
            cyc();
            t++;
        end
        if (t >= 100) chk("ready_timeout", bus.s_ready, 1);
        cyc();
    endtask

    task automatic wait_we(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.data_we && n < 60);
        if (!bus.data_we) n = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] e;
        int n;
        int we_seen;

        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.flush      = 1'b0;
        bus.credit_ret = 1'b0;

        // Reset values, with s_valid high to confirm s_ready stays low
        #2 reset_p = 1'b1;
        bus.s_valid = 1'b1;
        cyc();
        chk("rst_we",      bus.data_we,    0);
        chk("rst_size",    bus.size_o,     0);
        chk("rst_data",    bus.data_o,     0);
        chk("rst_credit",  bus.credit_cnt, 32);
        chk("rst_err",     bus.credit_err, 0);
        chk("rst_ready",   bus.s_ready,    0);
        bus.s_valid = 1'b0;
        reset_p = 1'b0;
        #1;
        chk("post_rst_ready", bus.s_ready, 1);

        // Full line of 16 words
        e = '0;
        for (int k = 0; k < 16; k++) begin
            feed(16'(k + 1));
            e[16*k +: 16] = 16'(k + 1);
        end
        bus.s_valid = 1'b0;
        chk("t1_we_early", bus.data_we, 0);
        chk("t1_ready_emit", bus.s_ready, 0);
        wait_we(n);
        chk("t1_latency", n, 1);
        chk("t1_size",    bus.size_o, 0);
        chk("t1_data",    bus.data_o, e);
        chk("t1_credit",  bus.credit_cnt, 16);
        cyc();
        chk("t1_we_pulse", bus.data_we, 0);
        chk("t1_hold",     bus.data_o, e);

        // Flush of a partial line
        do_reset();
        e = '0;
        for (int k = 0; k < 3; k++) begin
            feed(16'hA001 + 16'(k));
            e[16*k +: 16] = 16'hA001 + 16'(k);
        end
        bus.s_valid = 1'b0;
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        wait_we(n);
        chk("t2_latency", n, 1);
        chk("t2_size",    bus.size_o, 3);
        chk("t2_data",    bus.data_o, e);
        chk("t2_credit",  bus.credit_cnt, 29);

        // Idle timeout on a partial line
        do_reset();
        for (int k = 0; k < 5; k++) feed(16'h0B00 + 16'(k));
        bus.s_valid = 1'b0;
        wait_we(n);
        chk("t3_latency", n, 9);
        chk("t3_size",    bus.size_o, 5);
        chk("t3_credit",  bus.credit_cnt, 27);

        // Credit exhaustion and WAIT_CREDIT
        do_reset();
        for (int k = 0; k < 48; k++) feed(16'h0C00 + 16'(k));
        bus.s_valid = 1'b0;
        cyc();
        cyc();
        chk("t4_state",  dut.state_q, WAIT_CREDIT);
        chk("t4_ready",  bus.s_ready, 0);
        chk("t4_credit", bus.credit_cnt, 0);
        chk("t4_we",     bus.data_we, 0);
        for (int k = 0; k < 16; k++) begin
            bus.credit_ret = 1'b1;
            cyc();
        end
        bus.credit_ret = 1'b0;
        chk("t4_credit16", bus.credit_cnt, 16);
        chk("t4_we_early", bus.data_we, 0);
        wait_we(n);
        chk("t4_latency", n, 1);
        chk("t4_size",    bus.size_o, 0);
        chk("t4_credit0", bus.credit_cnt, 0);
        chk("t4_state_fill", dut.state_q, FILL);

        // Simultaneous emission and return, then overflow
        do_reset();
        for (int k = 0; k < 16; k++) feed(16'h0D00 + 16'(k));
        bus.s_valid = 1'b0;
        wait_we(n);
        for (int k = 0; k < 4; k++) begin
            bus.credit_ret = 1'b1;
            cyc();
        end
        bus.credit_ret = 1'b0;
        chk("t5_credit20", bus.credit_cnt, 20);
        for (int k = 0; k < 16; k++) feed(16'h0E00 + 16'(k));
        bus.s_valid = 1'b0;
        bus.credit_ret = 1'b1;
        cyc();
        bus.credit_ret = 1'b0;
        chk("t5_we",       bus.data_we, 1);
        chk("t5_credit5",  bus.credit_cnt, 5);
        for (int k = 0; k < 27; k++) begin
            bus.credit_ret = 1'b1;
            cyc();
        end
        bus.credit_ret = 1'b0;
        chk("t5_credit32", bus.credit_cnt, 32);
        chk("t5_err0",     bus.credit_err, 0);
        bus.credit_ret = 1'b1;
        cyc();
        bus.credit_ret = 1'b0;
        chk("t5_ovf_credit", bus.credit_cnt, 32);
        chk("t5_err1",       bus.credit_err, 1);
        cyc();
        chk("t5_err_sticky", bus.credit_err, 1);

        // Reset while holding 10 words in WAIT_CREDIT
        do_reset();
        for (int k = 0; k < 32; k++) feed(16'h0F00 + 16'(k));
        for (int k = 0; k < 10; k++) feed(16'h0100 + 16'(k));
        bus.s_valid = 1'b0;
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        cyc();
        cyc();
        chk("t6_state", dut.state_q, WAIT_CREDIT);
        chk("t6_data_nz", (bus.data_o != '0), 1);
        reset_p = 1'b1;
        #1;
        chk("t6_rst_we",     bus.data_we,    0);
        chk("t6_rst_data",   bus.data_o,     0);
        chk("t6_rst_size",   bus.size_o,     0);
        chk("t6_rst_credit", bus.credit_cnt, 32);
        chk("t6_rst_ready",  bus.s_ready,    0);
        chk("t6_rst_state",  dut.state_q,    FILL);
        cyc();
        reset_p = 1'b0;
        #1;
        we_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.data_we) we_seen++;
            cyc();
        end
        chk("t6_no_we",    we_seen, 0);
        chk("t6_ready",    bus.s_ready, 1);
        chk("t6_credit",   bus.credit_cnt, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
